writeback_stage: RTL

MEM/WB pipeline register and writeback driver for the five-stage MIPS datapath. It captures MEM-stage results and formats load data by size and sign. It then drives the RegWrite / WriteRegister / WriteData write port of the register file. It also supplies same-cycle write-through bypass on both read ports: the register file commits on the clock edge, so a decode-stage read in the writeback cycle would otherwise return the stale value.

---
 rtl/writeback_stage_if.sv | 44 ++++
 rtl/writeback_stage.sv | 109 ++++++++++
 2 files changed

// File: rtl/writeback_stage_if.sv
// writeback_stage_if -- MEM/WB bundle for the writeback stage.
// slave  : the writeback stage. It receives the Mem* fields, the stall/flush
//          controls and the decode read ports, and drives the register-file
//          write port and the bypassed read data.
// master : the surrounding pipeline, or a testbench.
interface writeback_stage_if;
  logic        Stall;
  logic        Flush;
  logic        MemValid;
  logic        MemRegWrite;
  logic        MemMemtoReg;
  logic        MemLink;
  logic [1:0]  MemLoadType;
  logic [4:0]  MemWriteRegister;
  logic [31:0] MemALUResult;
  logic [31:0] MemReadData;
  logic [31:0] MemPCPlus4;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic [31:0] RFReadData1;
  logic [31:0] RFReadData2;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic [31:0] BypassData1;
  logic [31:0] BypassData2;
  logic [31:0] RetiredCount;

  modport slave (
    input  Stall, Flush, MemValid, MemRegWrite, MemMemtoReg, MemLink,
           MemLoadType, MemWriteRegister, MemALUResult, MemReadData,
           MemPCPlus4, ReadRegister1, ReadRegister2, RFReadData1, RFReadData2,
    output RegWrite, WriteRegister, WriteData, BypassData1, BypassData2,
           RetiredCount
  );

  modport master (
    output Stall, Flush, MemValid, MemRegWrite, MemMemtoReg, MemLink,
           MemLoadType, MemWriteRegister, MemALUResult, MemReadData,
           MemPCPlus4, ReadRegister1, ReadRegister2, RFReadData1, RFReadData2,
    input  RegWrite, WriteRegister, WriteData, BypassData1, BypassData2,
           RetiredCount
  );
endinterface

// File: rtl/writeback_stage.sv
// writeback_stage -- MEM/WB pipeline register and register-file write driver.
// The stage captures the MEM results and formats load data by size and sign.
// It drives the register-file write port and forwards the writeback value
// into both decode read ports in the same cycle. The register file commits on
// the clock edge, so without this forwarding a read in that cycle would
// return the stale value.
// Ports:
//   Clk   : clock, rising edge
//   Reset : asynchronous, active high; clears all state
//   bus   : writeback_stage_if.slave (Mem* fields, Stall/Flush, read ports,
//           write port, bypass data, RetiredCount)
module writeback_stage (
  input  logic              Clk,
  input  logic              Reset,
  writeback_stage_if.slave  bus
);

  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic        memtoreg;
    logic        link;
    logic [1:0]  loadtype;
    logic [4:0]  dst;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] pc4;
  } wb_t;

  wb_t         wb_q, wb_d;
  logic [31:0] retired_q, retired_d;
  logic        retire;

  // Flush wins over Stall. On a flush only the valid bit matters; the other
  // fields are left as they are.
  always_comb begin
    wb_d = wb_q;
    if (bus.Flush) begin
      wb_d.valid = 1'b0;
    end else if (!bus.Stall) begin
      wb_d.valid    = bus.MemValid;
      wb_d.regwrite = bus.MemRegWrite;
      wb_d.memtoreg = bus.MemMemtoReg;
      wb_d.link     = bus.MemLink;
      wb_d.loadtype = bus.MemLoadType;
      wb_d.dst      = bus.MemWriteRegister;
      wb_d.alu      = bus.MemALUResult;
      wb_d.rdata    = bus.MemReadData;
      wb_d.pc4      = bus.MemPCPlus4;
    end
  end

  // The instruction leaving WB retires unless it is held. A flushed
  // instruction has already done its write, so it still counts.
  assign retire    = wb_q.valid & (bus.Flush | ~bus.Stall);
  assign retired_d = retire ? retired_q + 32'd1 : retired_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wb_q      <= '0;
      retired_q <= '0;
    end else begin
      wb_q      <= wb_d;
      retired_q <= retired_d;
    end
  end

  // Little-endian load formatting. Bit 0 of the address is ignored for
  // halfword loads.
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  always_comb begin
    ld_byte = 8'h00;
    case (wb_q.alu[1:0])
      2'd0: ld_byte = wb_q.rdata[7:0];
      2'd1: ld_byte = wb_q.rdata[15:8];
      2'd2: ld_byte = wb_q.rdata[23:16];
      2'd3: ld_byte = wb_q.rdata[31:24];
      default: ld_byte = 8'h00;
    endcase
    ld_half = wb_q.alu[1] ? wb_q.rdata[31:16] : wb_q.rdata[15:0];
    ld_data = wb_q.rdata;
    case (wb_q.loadtype)
      2'b00: ld_data = wb_q.rdata;
      2'b01: ld_data = {{16{ld_half[15]}}, ld_half};
      2'b10: ld_data = {{24{ld_byte[7]}}, ld_byte};
      2'b11: ld_data = {24'h0, ld_byte};
      default: ld_data = wb_q.rdata;
    endcase
  end

  logic        rf_we;
  logic [31:0] wr_data;

  // $zero is never written. Because of that it is never bypassed either.
  assign rf_we   = wb_q.valid & wb_q.regwrite & (wb_q.dst != 5'd0);
  assign wr_data = wb_q.link     ? wb_q.pc4 :
                   wb_q.memtoreg ? ld_data  : wb_q.alu;

  assign bus.RegWrite      = rf_we;
  assign bus.WriteRegister = wb_q.dst;
  assign bus.WriteData     = wr_data;
  assign bus.RetiredCount  = retired_q;
  assign bus.BypassData1   = (rf_we && wb_q.dst == bus.ReadRegister1) ? wr_data : bus.RFReadData1;
  assign bus.BypassData2   = (rf_we && wb_q.dst == bus.ReadRegister2) ? wr_data : bus.RFReadData2;

endmodule
